// File: rtl/ux607_spi_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ux607_spi_xfer_ctrl_if
// Purpose  : Command / response channel of the SPI byte sequencer.
//            The master side issues byte commands (with the sck divider to
//            use) and receives one response byte per command.
// Ports    : sck_div   - sck half-period divider, sampled at command accept
//            cmd_valid - command present
//            cmd_ready - controller idle and able to accept
//            cmd_data  - byte to transmit
//            cmd_quad  - 1 = x4 nibble mode, 0 = x1 full duplex
//            cmd_rx    - quad only: 1 = receive, 0 = transmit
//            cmd_last  - close the frame (raise cs_0) after this byte
//            rsp_valid - one-cycle pulse, rsp_data valid, no backpressure
//            rsp_data  - byte captured from the bus
// Revision : 1.0 - initial release
// ============================================================================
interface ux607_spi_xfer_ctrl_if #(
  parameter int DIV_W = 8
);
  logic [DIV_W-1:0] sck_div;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_data;
  logic             cmd_quad;
  logic             cmd_rx;
  logic             cmd_last;
  logic             rsp_valid;
  logic [7:0]       rsp_data;

  // Command issuer (e.g. a CPU-side register block)
  modport master (
    output sck_div, cmd_valid, cmd_data, cmd_quad, cmd_rx, cmd_last,
    input  cmd_ready, rsp_valid, rsp_data
  );

  // Sequencer side
  modport slave (
    input  sck_div, cmd_valid, cmd_data, cmd_quad, cmd_rx, cmd_last,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/ux607_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ux607_spi_xfer_ctrl
// Purpose  : Byte-level SPI master sequencer (mode 0, MSB first) for the
//            io_spi_* side of the GPIO port. Each accepted command shifts one
//            byte in x1 full-duplex or x4 nibble mode and returns one
//            response byte. Input capture is delayed by SYNC_DLY clocks to
//            line up with the port's input synchronizer.
// Ports    : clock      - core clock
//            reset      - asynchronous, active-high reset
//            cmd        - command/response channel (slave modport)
//            busy       - frame open or transfer in progress
//            spi_sck    - serial clock to io_spi_sck
//            spi_cs_0   - chip select, active low
//            spi_dq_o   - data out to io_spi_dq_[3:0]_o
//            spi_dq_oe  - output enables to io_spi_dq_[3:0]_oe
//            spi_dq_i   - synchronized pin data from io_spi_dq_[3:0]_i
// Revision : 1.0 - initial release
// ============================================================================
module ux607_spi_xfer_ctrl #(
  parameter int DIV_W    = 8,
  parameter int SYNC_DLY = 3   // must be >= 1 and equal the port sync depth
) (
  input  wire logic              clock,
  input  wire logic              reset,
  ux607_spi_xfer_ctrl_if.slave   cmd,
  output logic                   busy,
  output logic                   spi_sck,
  output logic                   spi_cs_0,
  output logic [3:0]             spi_dq_o,
  output logic [3:0]             spi_dq_oe,
  input  wire logic [3:0]        spi_dq_i
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_CS_HOLD  = 3'd4,
    ST_CS_GAP   = 3'd5
  } state_t;

  // All delay-line stages except the output one; strobes still in these
  // stages mean a capture is still pending beyond the current cycle.
  localparam logic [SYNC_DLY-1:0] c_dly_pend_mask = {SYNC_DLY{1'b1}} >> 1;
  localparam logic [SYNC_DLY-1:0] c_dly_lsb       = SYNC_DLY'(1);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [DIV_W-1:0] r_div;        // divider latched at accept
  logic [DIV_W-1:0] r_cnt;        // half-phase down counter
  logic             r_phase;      // 0 = sck low half, 1 = sck high half
  logic [2:0]       r_unit;       // bit (x1) or nibble (x4) index
  logic [7:0]       r_tx;         // transmit shift register, MSB on the wire
  logic [7:0]       r_rx;         // receive shift register
  logic             r_quad;
  logic             r_rx_mode;    // quad receive: outputs tri-stated
  logic             r_last;
  logic             r_frame_open; // cs_0 held low between commands
  logic [SYNC_DLY-1:0] r_dly;     // sample strobes in flight
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_data;

  logic             w_accept;
  logic             w_cnt_zero;
  logic             w_last_unit;
  logic             w_load;       // reload r_cnt from r_div
  logic             w_rise;       // sck goes 0->1 at the coming edge
  logic             w_unit_end;   // sck goes 1->0 at the coming edge
  logic             w_rsp_fire;
  logic             w_dly_clear;
  logic             w_drive;
  logic [7:0]       w_rx_shift;

  assign w_accept    = (r_state == ST_IDLE) && cmd.cmd_valid;
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_last_unit = r_quad ? (r_unit == 3'd1) : (r_unit == 3'd7);
  assign w_dly_clear = ((r_dly & c_dly_pend_mask) == '0);
  assign w_rx_shift  = r_quad ? {r_rx[3:0], spi_dq_i} : {r_rx[6:0], spi_dq_i[1]};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and datapath strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_rise      = 1'b0;
    w_unit_end  = 1'b0;
    w_rsp_fire  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          // An open frame skips the chip-select setup time.
          w_state_nxt = r_frame_open ? ST_SHIFT : ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (w_cnt_zero) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_cnt_zero) begin
          w_load = 1'b1;
          if (!r_phase) begin
            w_rise = 1'b1;
          end else begin
            w_unit_end = 1'b1;
            if (w_last_unit) begin
              w_state_nxt = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        // Leave once the only strobe left (if any) is capturing this cycle;
        // that final sample is merged straight into the response.
        if (w_dly_clear) begin
          w_rsp_fire  = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = r_last ? ST_CS_HOLD : ST_IDLE;
        end
      end
      ST_CS_HOLD: begin
        if (w_cnt_zero) begin
          w_load      = 1'b1;
          w_state_nxt = ST_CS_GAP;
        end
      end
      ST_CS_GAP: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div        <= '0;
      r_cnt        <= '0;
      r_phase      <= 1'b0;
      r_unit       <= 3'd0;
      r_tx         <= 8'h00;
      r_rx         <= 8'h00;
      r_quad       <= 1'b0;
      r_rx_mode    <= 1'b0;
      r_last       <= 1'b0;
      r_frame_open <= 1'b0;
      r_dly        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= 8'h00;
    end else begin
      r_dly       <= (r_dly << 1) | (w_rise ? c_dly_lsb : '0);
      r_rsp_valid <= w_rsp_fire;

      if (w_accept) begin
        r_div        <= cmd.sck_div;
        r_cnt        <= cmd.sck_div;
        r_tx         <= cmd.cmd_data;
        r_quad       <= cmd.cmd_quad;
        // x1 is always full duplex, so the rx flag only matters in quad.
        r_rx_mode    <= cmd.cmd_quad & cmd.cmd_rx;
        r_last       <= cmd.cmd_last;
        r_phase      <= 1'b0;
        r_unit       <= 3'd0;
        r_rx         <= 8'h00;
        r_frame_open <= 1'b1;
      end else begin
        if (w_load) begin
          r_cnt <= r_div;
        end else if (!w_cnt_zero) begin
          r_cnt <= r_cnt - DIV_W'(1);
        end

        if (w_rise) begin
          r_phase <= 1'b1;
        end

        if (w_unit_end) begin
          r_phase <= 1'b0;
          r_unit  <= r_unit + 3'd1;
          // The last unit's data is held through DRAIN.
          if (!w_last_unit) begin
            r_tx <= r_quad ? {r_tx[3:0], 4'h0} : {r_tx[6:0], 1'b0};
          end
        end

        if (r_dly[SYNC_DLY-1]) begin
          r_rx <= w_rx_shift;
        end

        if (w_rsp_fire) begin
          r_rsp_data <= r_dly[SYNC_DLY-1] ? w_rx_shift : r_rx;
          if (r_last) begin
            r_frame_open <= 1'b0;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from registers so reset forces them immediately)
  // --------------------------------------------------------------------------
  assign w_drive = (r_state == ST_SHIFT) || (r_state == ST_DRAIN);

  always_comb begin
    spi_dq_o  = 4'h0;
    spi_dq_oe = 4'h0;
    if (w_drive) begin
      if (!r_quad) begin
        spi_dq_o  = {3'b000, r_tx[7]};
        spi_dq_oe = 4'b0001;
      end else if (!r_rx_mode) begin
        spi_dq_o  = r_tx[7:4];
        spi_dq_oe = 4'hF;
      end
    end
  end

  assign spi_sck       = (r_state == ST_SHIFT) && r_phase;
  assign spi_cs_0      = !(r_frame_open || (r_state == ST_CS_HOLD));
  assign busy          = (r_state != ST_IDLE) || r_frame_open;
  assign cmd.cmd_ready = (r_state == ST_IDLE);
  assign cmd.rsp_valid = r_rsp_valid;
  assign cmd.rsp_data  = r_rsp_data;

endmodule
`default_nettype wire
